// File: rtl/alu_pkg.sv
// alu_pkg: types and constants shared by the ALU datapath blocks.
//   serial_state_e : control state of the bit-serial adder/subtractor
//   OP_ADD/OP_SUB  : encoding of the i_sub operation select
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } serial_state_e;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/full_adder.sv
// full_adder: one-bit full-adder cell.
//   i_a, i_b, i_cin : cell inputs
//   o_sum, o_cout   : sum and carry out
//   INVERT_B        : when 1, B is complemented inside the cell
module full_adder #(
    parameter bit INVERT_B = 1'b0
) (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    logic w_b;

    assign w_b    = INVERT_B ? ~i_b : i_b;
    assign o_sum  = i_a ^ w_b ^ i_cin;
    assign o_cout = (i_a & w_b) | (i_a & i_cin) | (w_b & i_cin);

endmodule

// File: rtl/serial_add_sub.sv
// serial_add_sub: bit-serial WIDTH-bit adder/subtractor, one bit per clock
// through a single full-adder cell with a registered carry.
//   clk, rst_n              : clock, synchronous active-low reset
//   i_valid/o_ready         : operand handshake (i_a, i_b, i_sub)
//   o_valid/i_ready         : result handshake (o_result and flags)
//   o_carry                 : carry out (subtract: 1 = no borrow)
//   o_overflow              : signed two's-complement overflow
//   o_zero                  : o_result == 0
//   o_state                 : current control state, for observation
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. o_ready is high only in IDLE and o_valid only in DONE, so the
// unit holds one operation at a time; requests seen outside IDLE are not
// queued and the requester must keep i_valid up. Once o_valid rises, the
// result and flags hold until the edge where i_ready is seen.
module serial_add_sub
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_sub,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_carry,
    output logic             o_overflow,
    output logic             o_zero,
    output serial_state_e    o_state
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    serial_state_e    r_state;
    serial_state_e    w_next_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_shift_a;
    logic [WIDTH-1:0] r_shift_b;
    logic [WIDTH-1:0] r_result;
    logic             r_carry;
    logic             r_c_msb_in;

    logic             w_accept;
    logic             w_last;
    logic             w_sum;
    logic             w_cout;

    assign w_accept = (r_state == IDLE) && i_valid;
    assign w_last   = (r_cnt == LAST_BIT);

    // B is already inverted at load time for subtraction, so the cell
    // is a plain adder.
    full_adder #(
        .INVERT_B (1'b0)
    ) u_cell (
        .i_a    (r_shift_a[0]),
        .i_b    (r_shift_b[0]),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = RUN;
            RUN:     if (w_last)   w_next_state = DONE;
            DONE:    if (i_ready)  w_next_state = IDLE;
            default:               w_next_state = IDLE;
        endcase
    end

    // Datapath: operand shifters, result shifter, carry and counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            r_shift_a  <= '0;
            r_shift_b  <= '0;
            r_result   <= '0;
            r_carry    <= 1'b0;
            r_c_msb_in <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt      <= '0;
                        r_shift_a  <= i_a;
                        r_shift_b  <= (i_sub == OP_SUB) ? ~i_b : i_b;
                        r_carry    <= (i_sub == OP_SUB);
                        r_result   <= '0;
                        r_c_msb_in <= 1'b0;
                    end
                end
                RUN: begin
                    // LSB-first: each sum bit enters at the MSB, so after
                    // WIDTH shifts bit 0 has reached position 0.
                    r_result  <= {w_sum, r_result[WIDTH-1:1]};
                    r_shift_a <= r_shift_a >> 1;
                    r_shift_b <= r_shift_b >> 1;
                    r_carry   <= w_cout;
                    r_cnt     <= r_cnt + CW'(1);
                    // Carry into the sign bit; overflow is its XOR with the
                    // carry out of the sign bit.
                    if (w_last) begin
                        r_c_msb_in <= r_carry;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs are decoded from registers only.
    always_comb begin
        o_ready    = (r_state == IDLE);
        o_valid    = (r_state == DONE);
        o_result   = r_result;
        o_carry    = 1'b0;
        o_overflow = 1'b0;
        o_zero     = 1'b0;
        o_state    = r_state;
        if (r_state == DONE) begin
            o_carry    = r_carry;
            o_overflow = r_c_msb_in ^ r_carry;
            o_zero     = (r_result == '0);
        end
    end

endmodule
